axi4_lite_wf_loader: RTL and testbench

AXI4_LITE_WF_LOADER -- requirements
Module: axi4_lite_wf_loader

---
 rtl/axi4_lite_wf_pkg.sv | 35 +++
 rtl/axi4_lite_wr_capture.sv | 68 ++++++
 rtl/axi4_lite_wf_loader.sv | 184 ++++++++++++++++++
 tb/tb_axi4_lite_wf_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_wf_pkg.sv
// Shared constants and types for the AXI4-Lite waveform loader.
// Register offsets, response codes and the captured write bundle.
package axi4_lite_wf_pkg;

  localparam int REG_NUM = 8;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CH_SEL = 3'd1;
  localparam logic [2:0] OFF_PTR    = 3'd2;
  localparam logic [2:0] OFF_DATA   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CNT0   = 3'd5;
  localparam logic [2:0] OFF_CNT1   = 3'd6;
  localparam logic [2:0] OFF_CNT2   = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [2:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return (old & ~m) | (din & m);
  endfunction

endpackage

// File: rtl/axi4_lite_wr_capture.sv
// AXI4-Lite write channel capture: holds AW and W independently,
// issues a single-cycle commit strobe and owns the B response.
module axi4_lite_wr_capture
  import axi4_lite_wf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output wr_req_t     req,
  output logic        commit,
  input  logic        err
);

  logic aw_held;
  logic w_held;
  logic aw_take;
  logic w_take;
  logic unused_ok;

  // Nothing new is taken while a response is outstanding.
  assign aw_take = awvalid && !aw_held && !bvalid;
  assign w_take  = wvalid && !w_held && !bvalid;
  assign commit  = aw_held && w_held && !bvalid;

  assign unused_ok = &{1'b0, awaddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      req     <= '0;
    end else begin
      awready <= aw_take;
      wready  <= w_take;
      if (aw_take) begin
        aw_held <= 1'b1;
        req.off <= awaddr[4:2];
      end
      if (w_take) begin
        w_held   <= 1'b1;
        req.data <= wdata;
        req.strb <= wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_wf_loader.sv
// AXI4-Lite slave that loads waveform words into per-channel BRAMs
// and exposes run enables and playback counters.
module axi4_lite_wf_loader
  import axi4_lite_wf_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CH_NUM             = 2,
  parameter int WF_ADDR_WIDTH      = 17,
  parameter int WF_DEPTH           = 2**WF_ADDR_WIDTH
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [4:0]                      S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [31:0]                     S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [4:0]                      S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [31:0]                     S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [WF_ADDR_WIDTH-1:0]        o_wf_addr,
  output logic [31:0]                     o_wf_din,
  output logic [CH_NUM-1:0]               o_wf_we,
  output logic [CH_NUM-1:0]               o_wf_en,
  input  logic [CH_NUM*WF_ADDR_WIDTH-1:0] i_wf_cnt
);

  localparam int CSW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  wr_req_t                  req;
  logic                     commit;
  logic                     wr_err;
  logic [31:0]              mrg;
  logic [CH_NUM-1:0]        ctrl_q;
  logic [CSW-1:0]           ch_sel_q;
  logic [WF_ADDR_WIDTH-1:0] ptr_q;
  logic                     status_q;
  logic [31:0]              rd_val;
  logic                     rd_err;
  logic [WF_ADDR_WIDTH-1:0] cnt_k [3];
  logic                     unused_ok;

  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_ARADDR[1:0]};

  axi4_lite_wr_capture u_wr (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .req     (req),
    .commit  (commit),
    .err     (wr_err)
  );

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    if (k < CH_NUM) begin : g_on
      assign cnt_k[k] = i_wf_cnt[k*WF_ADDR_WIDTH +: WF_ADDR_WIDTH];
    end else begin : g_off
      assign cnt_k[k] = '0;
    end
  end

  always_comb begin
    wr_err = 1'b0;
    mrg    = 32'h0;
    unique case (req.off)
      OFF_CTRL: begin
        mrg = strb_merge(32'(ctrl_q), req.data, req.strb);
      end
      OFF_CH_SEL: begin
        mrg    = strb_merge(32'(ch_sel_q), req.data, req.strb);
        wr_err = mrg >= 32'(CH_NUM);
      end
      OFF_PTR: begin
        mrg    = strb_merge(32'(ptr_q), req.data, req.strb);
        wr_err = mrg >= 32'(WF_DEPTH);
      end
      OFF_DATA: begin
        // A running channel must not be overwritten under playback.
        wr_err = (req.strb != 4'hF) || ctrl_q[ch_sel_q];
      end
      OFF_STATUS: wr_err = 1'b0;
      default:    wr_err = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      ch_sel_q  <= '0;
      ptr_q     <= '0;
      status_q  <= 1'b0;
      o_wf_we   <= '0;
      o_wf_addr <= '0;
      o_wf_din  <= '0;
    end else begin
      o_wf_we <= '0;
      if (commit && wr_err) begin
        status_q <= 1'b1;
      end else if (commit) begin
        unique case (req.off)
          OFF_CTRL:   ctrl_q   <= mrg[CH_NUM-1:0];
          OFF_CH_SEL: ch_sel_q <= mrg[CSW-1:0];
          OFF_PTR:    ptr_q    <= mrg[WF_ADDR_WIDTH-1:0];
          OFF_DATA: begin
            o_wf_we   <= CH_NUM'(1) << ch_sel_q;
            o_wf_addr <= ptr_q;
            o_wf_din  <= req.data;
            ptr_q     <= (ptr_q == WF_ADDR_WIDTH'(WF_DEPTH - 1)) ?
                         '0 : ptr_q + 1'b1;
          end
          OFF_STATUS: begin
            if (req.strb[0] && req.data[0]) status_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_wf_en = ctrl_q;

  always_comb begin
    rd_val = 32'h0;
    rd_err = 1'b0;
    unique case (S_AXI_ARADDR[4:2])
      OFF_CTRL:   rd_val = 32'(ctrl_q);
      OFF_CH_SEL: rd_val = 32'(ch_sel_q);
      OFF_PTR:    rd_val = 32'(ptr_q);
      OFF_DATA:   rd_val = 32'h0;
      OFF_STATUS: rd_val = {31'h0, status_q};
      OFF_CNT0:   rd_val = 32'(cnt_k[0]);
      OFF_CNT1: begin
        if (CH_NUM > 1) rd_val = 32'(cnt_k[1]);
        else rd_err = 1'b1;
      end
      OFF_CNT2: begin
        if (CH_NUM > 2) rd_val = 32'(cnt_k[2]);
        else rd_err = 1'b1;
      end
      default: rd_err = 1'b1;
    endcase
  end

  // Read data is sampled at the address handshake edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= 32'h0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_err ? 32'h0 : rd_val;
        S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_wf_loader.sv
// Directed self-checking bench for axi4_lite_wf_loader.
// Default parameters: CH_NUM=2, WF_ADDR_WIDTH=17.
module tb_axi4_lite_wf_loader;

  localparam int CH  = 2;
  localparam int AW  = 17;
  localparam int DEP = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [4:0]    araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [AW-1:0] wf_addr;
  logic [31:0]   wf_din;
  logic [CH-1:0] wf_we;
  logic [CH-1:0] wf_en;
  logic [CH*AW-1:0] wf_cnt;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [CH-1:0] last_we = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   last_din = '0;

  always #5 clk = ~clk;

  axi4_lite_wf_loader #(
    .C_S_AXI_DATA_WIDTH (32),
    .CH_NUM             (CH),
    .WF_ADDR_WIDTH      (AW)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .o_wf_addr     (wf_addr),
    .o_wf_din      (wf_din),
    .o_wf_we       (wf_we),
    .o_wf_en       (wf_en),
    .i_wf_cnt      (wf_cnt)
  );

  // Counts every cycle with a BRAM write enable high.
  always @(negedge clk) begin
    if (wf_we != '0) begin
      we_cnt    = we_cnt + 1;
      last_we   = wf_we;
      prev_addr = last_addr;
      last_addr = wf_addr;
      last_din  = wf_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [2:0] off, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, b_done, hs_aw, hs_w;
    aw_done = 0; w_done = 0; b_done = 0; resp = 2'b11;
    @(negedge clk);
    awaddr = {off, 2'b00}; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
    end
    for (int n = 0; n < 40 && !b_done; n++) begin
      @(negedge clk);
      if (bvalid) begin
        resp = bresp; b_done = 1;
        @(posedge clk); #1;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_done", 32'(aw_done && w_done && b_done), 32'd1);
  endtask

  task automatic axi_read(input logic [2:0] off, output logic [31:0] d,
                          output logic [1:0] resp);
    bit a_done, r_done, hs;
    a_done = 0; r_done = 0; d = 32'hx; resp = 2'b11;
    @(negedge clk);
    araddr = {off, 2'b00}; arvalid = 1'b1;
    for (int n = 0; n < 40 && !a_done; n++) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 1'b0; a_done = 1; end
    end
    for (int n = 0; n < 40 && !r_done; n++) begin
      @(negedge clk);
      if (rvalid) begin
        d = rdata; resp = rresp; r_done = 1;
        @(posedge clk); #1;
      end
    end
    arvalid = 1'b0;
    chk("rd_done", 32'(a_done && r_done), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    int w0;
    int aw_pulses;
    int bhold;
    bit got_b;
    bit hs;

    rst_n = 1'b0;
    awaddr = '0; awprot = 3'b101; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b1;
    wf_cnt = '0;
    #1;
    chk("rst_hs", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk("rst_we_en", 32'({wf_we, wf_en}), 32'h0);
    chk("rst_addr", 32'(wf_addr), 32'h0);
    chk("rst_din", wf_din, 32'h0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    axi_read(3'd0, rd, rr);
    chk("rst_ctrl", rd, 32'h0);
    axi_read(3'd2, rd, rr);
    chk("rst_ptr", rd, 32'h0);

    // basic DATA load into channel 1
    axi_write(3'd1, 32'h1, 4'hF, br);
    chk("chsel_resp", 32'(br), 32'h0);
    axi_write(3'd2, 32'h5, 4'hF, br);
    chk("ptr_resp", 32'(br), 32'h0);
    w0 = we_cnt;
    axi_write(3'd3, 32'hDEADBEEF, 4'hF, br);
    chk("data_resp", 32'(br), 32'h0);
    chk("data_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("data_we", 32'(last_we), 32'h2);
    chk("data_addr", 32'(last_addr), 32'h5);
    chk("data_din", last_din, 32'hDEADBEEF);
    axi_read(3'd2, rd, rr);
    chk("ptr_inc", rd, 32'h6);

    // pointer wrap at the last word
    axi_write(3'd2, DEP - 1, 4'hF, br);
    chk("ptr_max_resp", 32'(br), 32'h0);
    w0 = we_cnt;
    axi_write(3'd3, 32'h11, 4'hF, br);
    axi_write(3'd3, 32'h22, 4'hF, br);
    chk("wrap_cnt", 32'(we_cnt - w0), 32'd2);
    chk("wrap_addr0", 32'(prev_addr), DEP - 1);
    chk("wrap_addr1", 32'(last_addr), 32'h0);
    axi_read(3'd2, rd, rr);
    chk("wrap_ptr", rd, 32'h1);

    // byte strobes and out-of-range register writes
    axi_write(3'd2, 32'hFFFF_FFAB, 4'b0001, br);
    axi_read(3'd2, rd, rr);
    chk("ptr_strb", rd, 32'hAB);
    axi_write(3'd2, DEP, 4'hF, br);
    chk("ptr_oor_resp", 32'(br), 32'h2);
    axi_read(3'd2, rd, rr);
    chk("ptr_oor_keep", rd, 32'hAB);
    axi_write(3'd1, 32'h2, 4'hF, br);
    chk("chsel_oor_resp", 32'(br), 32'h2);
    axi_read(3'd1, rd, rr);
    chk("chsel_oor_keep", rd, 32'h1);
    axi_write(3'd4, 32'h1, 4'hF, br);

    // loading a running channel is rejected
    axi_write(3'd0, 32'h1, 4'hF, br);
    chk("ctrl_en", 32'(wf_en), 32'h1);
    axi_write(3'd1, 32'h0, 4'hF, br);
    w0 = we_cnt;
    axi_write(3'd3, 32'h99, 4'hF, br);
    chk("run_resp", 32'(br), 32'h2);
    chk("run_no_we", 32'(we_cnt - w0), 32'd0);
    axi_read(3'd4, rd, rr);
    chk("status_set", rd, 32'h1);
    axi_write(3'd4, 32'h1, 4'hF, br);
    chk("status_w1c_resp", 32'(br), 32'h0);
    axi_read(3'd4, rd, rr);
    chk("status_clr", rd, 32'h0);
    axi_write(3'd0, 32'h0, 4'hF, br);
    chk("ctrl_off", 32'(wf_en), 32'h0);
    w0 = we_cnt;
    axi_write(3'd3, 32'h77, 4'h7, br);
    chk("part_strb_resp", 32'(br), 32'h2);
    chk("part_strb_no_we", 32'(we_cnt - w0), 32'd0);
    axi_write(3'd4, 32'h1, 4'hF, br);
    axi_write(3'd2, 32'd10, 4'hF, br);

    // W early, AW late, B back-pressured
    w0 = we_cnt;
    bready = 1'b0;
    @(negedge clk);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) wvalid = 1'b0;
    end
    chk("early_w_taken", 32'(wvalid), 32'h0);
    @(negedge clk);
    awaddr = {3'd3, 2'b00}; awvalid = 1'b1;
    aw_pulses = 0; got_b = 0; br = 2'b11;
    for (int n = 0; n < 20 && !got_b; n++) begin
      @(negedge clk);
      if (awready) aw_pulses++;
      if (bvalid) begin got_b = 1; br = bresp; end
    end
    chk("bp_got_b", 32'(got_b), 32'd1);
    bhold = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (bvalid) bhold++;
      if (awready) aw_pulses++;
    end
    awvalid = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b_done", 32'(bvalid), 32'h0);
    chk("bp_b_hold", 32'(bhold), 32'd4);
    chk("bp_aw_pulses", 32'(aw_pulses), 32'd1);
    chk("bp_one_commit", 32'(we_cnt - w0), 32'd1);
    chk("bp_addr", 32'(last_addr), 32'd10);
    chk("bp_din", last_din, 32'h55);
    chk("bp_resp", 32'(br), 32'h0);

    // counter readback and unmapped offset
    wf_cnt = {17'h01234, 17'h00042};
    axi_read(3'd6, rd, rr);
    chk("cnt1", rd, 32'h1234);
    chk("cnt1_resp", 32'(rr), 32'h0);
    axi_read(3'd5, rd, rr);
    chk("cnt0", rd, 32'h42);
    axi_read(3'd7, rd, rr);
    chk("cnt2_resp", 32'(rr), 32'h2);
    chk("cnt2_data", rd, 32'h0);
    axi_write(3'd5, 32'h1, 4'hF, br);
    chk("cnt_wr_resp", 32'(br), 32'h2);
    axi_write(3'd4, 32'h1, 4'hF, br);

    // reset while an address is held
    axi_write(3'd0, 32'h2, 4'hF, br);
    chk("pre_rst_en", 32'(wf_en), 32'h2);
    axi_read(3'd2, rd, rr);
    chk("pre_rst_ptr", rd, 32'd11);
    @(negedge clk);
    awaddr = {3'd3, 2'b00}; awvalid = 1'b1;
    got_b = 0;
    for (int n = 0; n < 20 && !got_b; n++) begin
      @(negedge clk);
      hs = awvalid && awready;
      @(posedge clk); #1;
      if (hs) begin awvalid = 1'b0; got_b = 1; end
    end
    chk("held_aw", 32'(got_b), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    w0 = we_cnt;
    rst_n = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("ar_hs", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk("ar_en_we", 32'({wf_en, wf_we}), 32'h0);
    chk("ar_addr", 32'(wf_addr), 32'h0);
    chk("ar_din", wf_din, 32'h0);
    chk("ar_rdata", rdata, 32'h0);
    chk("ar_resp", 32'({bresp, rresp}), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk) wvalid = 1'b0;
    chk("post_rst_no_we", 32'(we_cnt - w0), 32'd0);
    chk("post_rst_no_b", 32'(bvalid), 32'h0);
    axi_read(3'd2, rd, rr);
    chk("post_rst_ptr", rd, 32'h0);
    axi_read(3'd0, rd, rr);
    chk("post_rst_ctrl", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
